memgame_ctrl: RTL and testbench
===============================

// Module: memgame_ctrl
// PURPOSE
//  Game sequencer for the 16-card 4x4 memory/matching board rendered by the card draw system.
//  Owns per-card state (hidden/face-up/matched), the player cursor, pair comparison, reveal timing and score.
//  Takes debounced single-cycle button pulses and drives the packed card state and symbol buses read by the renderer.
// PARAMETERS
//  SHOW_CYCLES  25_000_000      cycles both picked cards stay face-up before resolution; must be >= 1
//  LAYOUT       48'hFAC688FAC688 3-bit symbol per card, card 0 in bits [2:0]; each symbol appears exactly twice
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   pulse: (re)start game from any state
//  btn_up/down/left/right in 1 each   pulse: move cursor
//  btn_sel      in   1   pulse: flip the card under the cursor
//  card_state   out  32  2 bits per card, card i at [2i+1:2i]: 00 hidden, 01 face-up, 10 matched
//  card_sym     out  48  active layout, 3 bits per card
//  cursor       out  4   selected card index, row = cursor[3:2], col = cursor[1:0]
//  moves        out  8   completed pair attempts, saturates at 255
//  pairs        out  4   matched pairs, 0..8
//  match_pulse  out  1   one-cycle pulse when a pair matches
//  game_over    out  1   high in DONE
// BEHAVIOUR
//  Reset: FSM=IDLE, card_state=0 (all hidden), cursor=0, moves=0, pairs=0, match_pulse=0, game_over=0, card_sym=LAYOUT.
//  FSM states: IDLE, PICK1, PICK2, SHOW, DONE.
//  start (any state): next cycle all cards hidden, cursor/moves/pairs=0, game_over=0, layout reloaded, FSM=PICK1.
//    start has priority over every other input in the same cycle.
//  Cursor: moves only in PICK1/PICK2; one move per cycle; priority up>down>left>right.
//    up/down change the row, left/right change the col, each modulo 4 (wrap within the row/column); cursor is
//    registered, so the new index is visible the cycle after the pulse.
//  A select in the same cycle as a move uses the pre-move cursor.
//  PICK1 + btn_sel on a hidden card: the card goes to 01, first_idx<=cursor, ->PICK2. Select on a face-up/matched card is ignored.
//  PICK2 + btn_sel on a hidden card: the card goes to 01, second_idx<=cursor, moves+=1 (sat), timer<=SHOW_CYCLES-1, ->SHOW.
//    Selecting first_idx again is ignored (that card is no longer hidden).
//  SHOW: timer decrements each cycle; all buttons except start are ignored.
//    On the cycle timer==0, resolve:
//    equal symbols: both cards ->10, pairs+=1, match_pulse=1 for this cycle; ->DONE if pairs becomes 8, else ->PICK1.
//    unequal symbols: both cards ->00, ->PICK1.
//    The reveal therefore lasts exactly SHOW_CYCLES cycles after the second flip registers.
//  DONE: game_over=1; everything except start is ignored; state is held.
//  IDLE: only start has an effect.
//  Reset mid-game: immediate return to reset values; no partial resolution.
// CONFIGURATION
//  MEMGAME_SHUFFLE_EN defined:
//    A 16-bit maximal LFSR (x^16+x^14+x^13+x^11, seed 16'hACE1 at reset) advances every cycle.
//    On start, offset<=lfsr[3:0] and card_sym[i] = LAYOUT symbol of card (i+offset) mod 16.
//    Pairing is preserved because a rotation keeps each symbol exactly twice.
//  MEMGAME_SHUFFLE_EN undefined: no LFSR, offset fixed at 0, card_sym==LAYOUT always.
// STRUCTURE
//  memgame_pkg: NUM_CARDS=16, SYM_W=3, card-state encodings (HIDDEN/FACEUP/MATCHED), FSM state
//    encoding, LFSR seed/taps.
//  Sub-module memgame_cursor: registered 4x4 cursor with wrap and priority encoding, enable input
//    driven by FSM (PICK1|PICK2), clear input driven by start.
//  Top: FSM, card-state array, reveal timer (width $clog2(SHOW_CYCLES)), counters, optional LFSR.
// TESTING  (SHOW_CYCLES=4 in bench)
//  1 Reset then start; right x5 -> cursor=1 (wraps in row 0 after col 3); down x4 -> cursor=1; up once -> cursor=13.
//  2 Select card 0, then card 8 (both symbol 0) -> both 01, moves=1; 4 cycles later both 10, match_pulse
//    high for 1 cycle, pairs=1, FSM=PICK1.
//  3 Select card 0, then card 1 -> moves=1; after 4 cycles both 00, pairs=0; button pulses during SHOW
//    change nothing.
//  4 Select card 3 twice in PICK1/PICK2 -> second select ignored, FSM stays PICK2, moves=0.
//  5 Match all 8 pairs -> pairs=8, game_over=1; further sel/moves ignored; start -> all 00, counters 0, PICK1.
//  6 rst_n low while in SHOW -> outputs return to reset values the same cycle; with MEMGAME_SHUFFLE_EN,
//    check every symbol appears twice in card_sym after start.

Source files
------------

// File: rtl/memgame_pkg.sv
// Shared constants and types for the 4x4 memory-game sequencer.
// Card-state and FSM encodings plus the LFSR constants used when MEMGAME_SHUFFLE_EN is defined.
package memgame_pkg;

   localparam int NUM_CARDS = 16;
   localparam int SYM_W     = 3;
   localparam int IDX_W     = 4;

   localparam logic [3:0] ALL_PAIRS = 4'd8;

   typedef enum logic [1:0] {
      CARD_HIDDEN  = 2'b00,
      CARD_FACEUP  = 2'b01,
      CARD_MATCHED = 2'b10
   } cardState_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PICK1,
      ST_PICK2,
      ST_SHOW,
      ST_DONE
   } fsmState_e;

   // Fibonacci taps for x^16+x^14+x^13+x^11 (bits 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/memgame_if.sv
// Button pulses in, board state out, between the game sequencer and its surroundings.
// master drives the buttons and observes the board; slave is the sequencer.
interface memgame_if;
   import memgame_pkg::*;

   logic                         start;
   logic                         btn_up;
   logic                         btn_down;
   logic                         btn_left;
   logic                         btn_right;
   logic                         btn_sel;
   logic [2*NUM_CARDS-1:0]       card_state;
   logic [SYM_W*NUM_CARDS-1:0]   card_sym;
   logic [IDX_W-1:0]             cursor;
   logic [7:0]                   moves;
   logic [3:0]                   pairs;
   logic                         match_pulse;
   logic                         game_over;

   modport master (
      output start, btn_up, btn_down, btn_left, btn_right, btn_sel,
      input  card_state, card_sym, cursor, moves, pairs, match_pulse, game_over
   );

   modport slave (
      input  start, btn_up, btn_down, btn_left, btn_right, btn_sel,
      output card_state, card_sym, cursor, moves, pairs, match_pulse, game_over
   );

endinterface

// File: rtl/memgame_cursor.sv
// Registered 4x4 board cursor: one move per cycle, priority up>down>left>right,
// row/col each wrap modulo 4; clear wins over enable.
module memgame_cursor
   import memgame_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             up_i,
   input  logic             down_i,
   input  logic             left_i,
   input  logic             right_i,
   output logic [IDX_W-1:0] cursor_o
);

   logic [1:0] row_q, row_d;
   logic [1:0] col_q, col_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   // 2-bit arithmetic gives the wrap within a row or column for free
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (enable_i) begin
         if (up_i)         row_d = row_q - 2'd1;
         else if (down_i)  row_d = row_q + 2'd1;
         else if (left_i)  col_d = col_q - 2'd1;
         else if (right_i) col_d = col_q + 2'd1;
      end
   end

   assign cursor_o = {row_q, col_q};

endmodule

// File: rtl/memgame_ctrl.sv
// Memory-game sequencer: FSM, per-card state, reveal timer, move/pair counters.
// Define MEMGAME_SHUFFLE_EN to rotate the layout by an LFSR-derived offset on every start.
module memgame_ctrl
   import memgame_pkg::*;
#(
   parameter int unsigned                  SHOW_CYCLES = 25_000_000,
   parameter logic [SYM_W*NUM_CARDS-1:0]   LAYOUT      = 48'hFAC688FAC688
) (
   input  logic      clk,
   input  logic      rst_n,
   memgame_if.slave  bus
);

   localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [NUM_CARDS-1:0][SYM_W-1:0] LAYOUT_ARR = LAYOUT;

   fsmState_e                      state_q, state_d;
   logic [NUM_CARDS-1:0][1:0]      cardState_q, cardState_d;
   logic [IDX_W-1:0]               firstIdx_q, firstIdx_d;
   logic [IDX_W-1:0]               secondIdx_q, secondIdx_d;
   logic [TIMER_W-1:0]             timer_q, timer_d;
   logic [7:0]                     moves_q, moves_d;
   logic [3:0]                     pairs_q, pairs_d;
   logic                           matchPulse_q, matchPulse_d;

   logic [IDX_W-1:0]               cursor;
   logic [IDX_W-1:0]               offset;
   logic [NUM_CARDS-1:0][SYM_W-1:0] symArr;
   logic                           cursorEn;

   assign cursorEn = (state_q == ST_PICK1) || (state_q == ST_PICK2);

   memgame_cursor u_cursor (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (cursorEn),
      .clear_i  (bus.start),
      .up_i     (bus.btn_up),
      .down_i   (bus.btn_down),
      .left_i   (bus.btn_left),
      .right_i  (bus.btn_right),
      .cursor_o (cursor)
   );

`ifdef MEMGAME_SHUFFLE_EN
   logic [15:0]      lfsr_q;
   logic [IDX_W-1:0] offset_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q   <= LFSR_SEED;
         offset_q <= '0;
      end else begin
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
         if (bus.start) offset_q <= lfsr_q[IDX_W-1:0];
      end
   end

   assign offset = offset_q;
`else
   assign offset = '0;
`endif

   // Rotating a period-8 layout keeps every symbol exactly twice
   always_comb begin
      for (int i = 0; i < NUM_CARDS; i++) begin
         symArr[i] = LAYOUT_ARR[IDX_W'(i) + offset];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cardState_q  <= '0;
         firstIdx_q   <= '0;
         secondIdx_q  <= '0;
         timer_q      <= '0;
         moves_q      <= '0;
         pairs_q      <= '0;
         matchPulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cardState_q  <= cardState_d;
         firstIdx_q   <= firstIdx_d;
         secondIdx_q  <= secondIdx_d;
         timer_q      <= timer_d;
         moves_q      <= moves_d;
         pairs_q      <= pairs_d;
         matchPulse_q <= matchPulse_d;
      end
   end

   // Selection uses the registered cursor, so a same-cycle move cannot redirect a flip
   always_comb begin
      state_d      = state_q;
      cardState_d  = cardState_q;
      firstIdx_d   = firstIdx_q;
      secondIdx_d  = secondIdx_q;
      timer_d      = timer_q;
      moves_d      = moves_q;
      pairs_d      = pairs_q;
      matchPulse_d = 1'b0;

      if (bus.start) begin
         state_d     = ST_PICK1;
         cardState_d = '0;
         timer_d     = '0;
         moves_d     = '0;
         pairs_d     = '0;
      end else begin
         case (state_q)
            ST_PICK1: begin
               if (bus.btn_sel && (cardState_q[cursor] == CARD_HIDDEN)) begin
                  cardState_d[cursor] = CARD_FACEUP;
                  firstIdx_d          = cursor;
                  state_d             = ST_PICK2;
               end
            end
            ST_PICK2: begin
               if (bus.btn_sel && (cardState_q[cursor] == CARD_HIDDEN)) begin
                  cardState_d[cursor] = CARD_FACEUP;
                  secondIdx_d         = cursor;
                  moves_d             = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
                  timer_d             = TIMER_LOAD;
                  state_d             = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (timer_q == '0) begin
                  if (symArr[firstIdx_q] == symArr[secondIdx_q]) begin
                     cardState_d[firstIdx_q]  = CARD_MATCHED;
                     cardState_d[secondIdx_q] = CARD_MATCHED;
                     pairs_d                  = pairs_q + 4'd1;
                     matchPulse_d             = 1'b1;
                     state_d                  = (pairs_d == ALL_PAIRS) ? ST_DONE : ST_PICK1;
                  end else begin
                     cardState_d[firstIdx_q]  = CARD_HIDDEN;
                     cardState_d[secondIdx_q] = CARD_HIDDEN;
                     state_d                  = ST_PICK1;
                  end
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.card_state  = cardState_q;
   assign bus.card_sym    = symArr;
   assign bus.cursor      = cursor;
   assign bus.moves       = moves_q;
   assign bus.pairs       = pairs_q;
   assign bus.match_pulse = matchPulse_q;
   assign bus.game_over   = (state_q == ST_DONE);

endmodule

// File: tb/tb_memgame_ctrl.sv
// Bench for memgame_ctrl: directed game scenarios plus random button traffic, checked every
// cycle against a rule-level model of the game. Honours MEMGAME_SHUFFLE_EN like the design.
`timescale 1ns/1ps
module tb_memgame_ctrl;

   localparam int          SHOW   = 4;
   localparam logic [47:0] LAYOUT = 48'hFAC688FAC688;

   localparam int B_UP = 1, B_DOWN = 2, B_LEFT = 4, B_RIGHT = 8, B_SEL = 16, B_START = 32;
   localparam int M_IDLE = 0, M_FIRST = 1, M_SECOND = 2, M_REVEAL = 3, M_FINISHED = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   memgame_if bus();

   memgame_ctrl #(
      .SHOW_CYCLES (SHOW),
      .LAYOUT      (LAYOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Game model: card status 0 hidden / 1 face-up / 2 matched, reveal ends at an absolute edge number
   int          mCard[16];
   int          mSym[16];
   int          mRow, mCol, mMoves, mPairs, mMode, mFirst, mSecond, mOffset;
   bit          mPulse;
   longint      edgeNo, revealAt;
   logic [15:0] mLfsr;

   int passCount  = 0;
   int checkCount = 0;
   bit cmpEn      = 1'b0;

   function automatic void loadSymbols();
      for (int i = 0; i < 16; i++) begin
         mSym[i] = int'((LAYOUT >> (3 * ((i + mOffset) % 16))) & 48'h7);
      end
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 16; i++) mCard[i] = 0;
      mRow = 0; mCol = 0; mMoves = 0; mPairs = 0; mMode = M_IDLE;
      mFirst = 0; mSecond = 0; mOffset = 0; mPulse = 1'b0;
      mLfsr = 16'hACE1; revealAt = 0;
      loadSymbols();
   endfunction

   function automatic void modelStep();
      int cur;
      edgeNo++;
      mPulse = 1'b0;
      cur = mRow * 4 + mCol;
      if (bus.start) begin
         for (int i = 0; i < 16; i++) mCard[i] = 0;
         mRow = 0; mCol = 0; mMoves = 0; mPairs = 0; mMode = M_FIRST;
`ifdef MEMGAME_SHUFFLE_EN
         mOffset = int'(mLfsr[3:0]);
`else
         mOffset = 0;
`endif
         loadSymbols();
      end else if (mMode == M_FIRST || mMode == M_SECOND) begin
         if (bus.btn_sel && mCard[cur] == 0) begin
            mCard[cur] = 1;
            if (mMode == M_FIRST) begin
               mFirst = cur;
               mMode  = M_SECOND;
            end else begin
               mSecond  = cur;
               mMoves   = (mMoves < 255) ? mMoves + 1 : 255;
               revealAt = edgeNo + SHOW;
               mMode    = M_REVEAL;
            end
         end
         if (bus.btn_up)         mRow = (mRow + 3) % 4;
         else if (bus.btn_down)  mRow = (mRow + 1) % 4;
         else if (bus.btn_left)  mCol = (mCol + 3) % 4;
         else if (bus.btn_right) mCol = (mCol + 1) % 4;
      end else if (mMode == M_REVEAL && edgeNo == revealAt) begin
         if (mSym[mFirst] == mSym[mSecond]) begin
            mCard[mFirst]  = 2;
            mCard[mSecond] = 2;
            mPairs++;
            mPulse = 1'b1;
            mMode  = (mPairs == 8) ? M_FINISHED : M_FIRST;
         end else begin
            mCard[mFirst]  = 0;
            mCard[mSecond] = 0;
            mMode          = M_FIRST;
         end
      end
`ifdef MEMGAME_SHUFFLE_EN
      mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
`endif
   endfunction

   function automatic logic [31:0] expState();
      logic [31:0] r = '0;
      for (int i = 0; i < 16; i++) r[2*i +: 2] = 2'(mCard[i]);
      return r;
   endfunction

   function automatic logic [47:0] expSym();
      logic [47:0] r = '0;
      for (int i = 0; i < 16; i++) r[3*i +: 3] = 3'(mSym[i]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of button pulses starting at a falling edge
   task automatic applyStimulus(input int mask);
      bus.btn_up    = (mask & B_UP)    != 0;
      bus.btn_down  = (mask & B_DOWN)  != 0;
      bus.btn_left  = (mask & B_LEFT)  != 0;
      bus.btn_right = (mask & B_RIGHT) != 0;
      bus.btn_sel   = (mask & B_SEL)   != 0;
      bus.start     = (mask & B_START) != 0;
      @(negedge clk);
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0;
      bus.btn_right = 0; bus.btn_sel = 0; bus.start = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0);
   endtask

   task automatic moveTo(input int target);
      for (int k = 0; k < 4 && mRow != target / 4; k++) applyStimulus(B_DOWN);
      for (int k = 0; k < 4 && mCol != target % 4; k++) applyStimulus(B_RIGHT);
   endtask

   task automatic flipPair(input int a, input int b);
      moveTo(a);
      applyStimulus(B_SEL);
      moveTo(b);
      applyStimulus(B_SEL);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else        modelStep();
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cmpEn) begin
         checkOutput("card_state",  64'(bus.card_state),  64'(expState()));
         checkOutput("card_sym",    64'(bus.card_sym),    64'(expSym()));
         checkOutput("cursor",      64'(bus.cursor),      64'(mRow * 4 + mCol));
         checkOutput("moves",       64'(bus.moves),       64'(mMoves));
         checkOutput("pairs",       64'(bus.pairs),       64'(mPairs));
         checkOutput("match_pulse", 64'(bus.match_pulse), 64'(mPulse));
         checkOutput("game_over",   64'(bus.game_over),   64'(mMode == M_FINISHED));
      end
   end

   initial begin
      int m;
      int symCount[8];
      logic [47:0] symBus;
      bus.start = 0; bus.btn_up = 0; bus.btn_down = 0;
      bus.btn_left = 0; bus.btn_right = 0; bus.btn_sel = 0;
      edgeNo = 0;
      modelReset();
      repeat (3) @(negedge clk);
      cmpEn = 1'b1;

      checkOutput("rst card_state", 64'(bus.card_state), 64'h0);
      checkOutput("rst card_sym",   64'(bus.card_sym),   64'(LAYOUT));
      checkOutput("rst cursor",     64'(bus.cursor),     64'h0);
      checkOutput("rst game_over",  64'(bus.game_over),  64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(B_SEL | B_RIGHT);
      checkOutput("idle ignores", 64'({bus.card_state, bus.cursor}), 64'h0);
      applyStimulus(B_START);

      repeat (5) applyStimulus(B_RIGHT);
      checkOutput("right x5", 64'(bus.cursor), 64'd1);
      repeat (4) applyStimulus(B_DOWN);
      checkOutput("down x4", 64'(bus.cursor), 64'd1);
      applyStimulus(B_UP);
      checkOutput("up wrap", 64'(bus.cursor), 64'd13);

      flipPair(0, 8);
      checkOutput("pair faceup", 64'(bus.card_state), 64'h0001_0001);
      checkOutput("moves 1",     64'(bus.moves),      64'd1);
      idle(SHOW - 1);
      checkOutput("still shown", 64'(bus.card_state), 64'h0001_0001);
      idle(1);
      checkOutput("matched",     64'(bus.card_state), 64'h0002_0002);
      checkOutput("pulse high",  64'(bus.match_pulse), 64'd1);
      checkOutput("pairs 1",     64'(bus.pairs),       64'd1);
      idle(1);
      checkOutput("pulse low",   64'(bus.match_pulse), 64'd0);

      moveTo(1);
      applyStimulus(B_SEL | B_RIGHT);
      checkOutput("sel pre-move", 64'({bus.card_state, bus.cursor}), 64'h0002_0006_2);
      applyStimulus(B_SEL);
      applyStimulus(B_UP | B_SEL);
      applyStimulus(B_LEFT);
      checkOutput("show frozen", 64'({bus.card_state, bus.cursor}), 64'h0002_0016_2);
      idle(SHOW - 2);
      checkOutput("mismatch hidden", 64'(bus.card_state), 64'h0002_0002);
      checkOutput("moves 2",         64'(bus.moves),      64'd2);

      moveTo(3);
      applyStimulus(B_SEL);
      applyStimulus(B_SEL);
      checkOutput("reselect ignored", 64'({bus.card_state, bus.moves}), 64'h0002_0042_02);
      moveTo(11);
      applyStimulus(B_SEL);
      idle(SHOW);
      checkOutput("pair 3/11", 64'(bus.card_state), 64'h0082_0082);

      flipPair(1, 9);  idle(SHOW);
      flipPair(2, 10); idle(SHOW);
      flipPair(4, 12); idle(SHOW);
      flipPair(5, 13); idle(SHOW);
      flipPair(6, 14); idle(SHOW);
      flipPair(7, 15); idle(SHOW);
      checkOutput("all matched", 64'(bus.card_state), 64'hAAAA_AAAA);
      checkOutput("pairs 8",     64'(bus.pairs),      64'd8);
      checkOutput("game_over",   64'(bus.game_over),  64'd1);
      checkOutput("moves 9",     64'(bus.moves),      64'd9);
      applyStimulus(B_SEL | B_UP);
      applyStimulus(B_LEFT);
      checkOutput("done frozen", 64'({bus.cursor, bus.pairs}), 64'hF8);
      applyStimulus(B_START);
      checkOutput("restart", 64'({bus.card_state, bus.moves, bus.pairs, bus.cursor, bus.game_over}), 64'h0);

      flipPair(4, 5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rst", 64'({bus.card_state, bus.moves, bus.cursor, bus.game_over}), 64'h0);
      checkOutput("async rst sym", 64'(bus.card_sym), 64'(LAYOUT));
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      applyStimulus(B_START);

`ifdef MEMGAME_SHUFFLE_EN
      symBus = bus.card_sym;
      for (int s = 0; s < 8; s++) symCount[s] = 0;
      for (int i = 0; i < 16; i++) symCount[symBus[3*i +: 3]]++;
      for (int s = 0; s < 8; s++) checkOutput("sym twice", 64'(symCount[s]), 64'd2);
`endif

      for (int n = 0; n < 4000; n++) begin
         m = 0;
         if ($urandom_range(0, 99) == 0) begin
            m = B_START | int'($urandom_range(0, 31));
         end else begin
            if ($urandom_range(0, 3) == 0) m = B_SEL;
            case ($urandom_range(0, 6))
               0: m |= B_UP;
               1: m |= B_DOWN;
               2: m |= B_LEFT;
               3: m |= B_RIGHT;
               4: m |= B_UP | B_RIGHT;
               5: m |= B_DOWN | B_LEFT | B_RIGHT;
               default: ;
            endcase
         end
         applyStimulus(m);
      end

      cmpEn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
